// File: rtl/rv32_mod_lsu_split.sv
// Load/store unit between the HART memory stage and the data bus.
// Registers each bus beat, splits word-crossing accesses into two beats, extends loads.
module rv32_mod_lsu_split #(
    parameter int MISALIGNED_SPLIT = 1,
    parameter int TIMEOUT_CYCLES   = 0,
    parameter int TO_W             = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_type,
    input  logic        wr,
    input  logic [31:0] address,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid,
    output logic        err,
    output logic [1:0]  err_cause,
    output logic        stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_data_o,
    input  logic        data_ack,
    input  logic        data_err,
    input  logic [31:0] data_data_i
);

    // state | meaning
    // IDLE  | no access in flight
    // BEAT0 | first (or only) bus beat outstanding
    // BEAT1 | upper beat of a split access outstanding
    // DONE  | one-cycle completion, valid=1
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t          state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic            wr_q, wr_d;
    logic            cross_q, cross_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be1_q, be1_d;
    logic [31:0]     asm_q, asm_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [31:0]     data_o_q, data_o_d;
    logic            err_q, err_d;
    logic [1:0]      err_cause_q, err_cause_d;
    logic            data_req_q, data_req_d;
    logic            data_wr_q, data_wr_d;
    logic [3:0]      data_be_q, data_be_d;
    logic [31:0]     data_addr_q, data_addr_d;
    logic [31:0]     data_data_o_q, data_data_o_d;

    logic            req_present;
    logic [3:0]      in_mask;
    logic [7:0]      in_lanes;
    logic            in_cross;
    logic [5:0]      beat1_shift;
    logic [31:0]     asm_hi, asm_lo;
    logic [63:0]     asm_sh;
    logic [31:0]     load_val;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [31:0] res;
        case (size)
            2'b01:   res = sgn ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            2'b10:   res = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign req_present = (req_type[1:0] != 2'b00);
    assign in_lanes    = {4'b0000, in_mask} << address[1:0];
    assign in_cross    = ((req_type[1:0] == 2'b10) && (address[1:0] == 2'b11)) ||
                         ((req_type[1:0] == 2'b11) && (address[1:0] != 2'b00));
    assign beat1_shift = {3'd4 - {1'b0, off_q}, 3'b000};

    always_comb begin
        case (req_type[1:0])
            2'b01:   in_mask = 4'b0001;
            2'b10:   in_mask = 4'b0011;
            2'b11:   in_mask = 4'b1111;
            default: in_mask = 4'b0000;
        endcase
    end

    // Upper beat supplies the high word; a single beat leaves it zero before the lane shift.
    always_comb begin
        asm_hi   = (state_q == BEAT1) ? data_data_i : 32'h0;
        asm_lo   = (state_q == BEAT1) ? asm_q : data_data_i;
        asm_sh   = {asm_hi, asm_lo} >> {off_q, 3'b000};
        load_val = extend(asm_sh[31:0], size_q, sign_q);
    end

    always_comb begin
        state_d       = state_q;
        off_d         = off_q;
        size_d        = size_q;
        sign_d        = sign_q;
        wr_d          = wr_q;
        cross_d       = cross_q;
        wdata_d       = wdata_q;
        be1_d         = be1_q;
        asm_d         = asm_q;
        to_d          = to_q;
        data_o_d      = data_o_q;
        err_d         = 1'b0;
        err_cause_d   = CAUSE_NONE;
        data_req_d    = data_req_q;
        data_wr_d     = data_wr_q;
        data_be_d     = data_be_q;
        data_addr_d   = data_addr_q;
        data_data_o_d = data_data_o_q;

        case (state_q)
            IDLE, DONE: begin
                state_d    = IDLE;
                data_req_d = 1'b0;
                if (req_present) begin
                    off_d   = address[1:0];
                    size_d  = req_type[1:0];
                    sign_d  = req_type[3];
                    wr_d    = wr;
                    cross_d = in_cross;
                    wdata_d = data_i;
                    be1_d   = in_lanes[7:4];
                    if (in_cross && (MISALIGNED_SPLIT == 0)) begin
                        state_d     = DONE;
                        err_d       = 1'b1;
                        err_cause_d = CAUSE_MISALGN;
                    end else begin
                        state_d       = BEAT0;
                        to_d          = '0;
                        data_req_d    = 1'b1;
                        data_wr_d     = wr;
                        data_be_d     = in_lanes[3:0];
                        data_addr_d   = {address[31:2], 2'b00};
                        data_data_o_d = wr ? (data_i << {address[1:0], 3'b000}) : 32'h0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (data_err) begin
                    state_d     = DONE;
                    data_req_d  = 1'b0;
                    err_d       = 1'b1;
                    err_cause_d = CAUSE_BUSERR;
                end else if (data_ack) begin
                    if ((state_q == BEAT0) && cross_q) begin
                        state_d       = BEAT1;
                        to_d          = '0;
                        asm_d         = data_data_i;
                        data_be_d     = be1_q;
                        data_addr_d   = data_addr_q + 32'd4;
                        data_data_o_d = wr_q ? (wdata_q >> beat1_shift) : 32'h0;
                    end else begin
                        state_d    = DONE;
                        data_req_d = 1'b0;
                        data_o_d   = wr_q ? 32'h0 : load_val;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (to_q == TO_LAST)) begin
                    state_d     = DONE;
                    data_req_d  = 1'b0;
                    to_d        = to_q + TO_W'(1);
                    err_d       = 1'b1;
                    err_cause_d = CAUSE_TIMEOUT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            off_q         <= 2'b00;
            size_q        <= 2'b00;
            sign_q        <= 1'b0;
            wr_q          <= 1'b0;
            cross_q       <= 1'b0;
            wdata_q       <= 32'h0;
            be1_q         <= 4'h0;
            asm_q         <= 32'h0;
            to_q          <= '0;
            data_o_q      <= 32'h0;
            err_q         <= 1'b0;
            err_cause_q   <= CAUSE_NONE;
            data_req_q    <= 1'b0;
            data_wr_q     <= 1'b0;
            data_be_q     <= 4'h0;
            data_addr_q   <= 32'h0;
            data_data_o_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            wr_q          <= wr_d;
            cross_q       <= cross_d;
            wdata_q       <= wdata_d;
            be1_q         <= be1_d;
            asm_q         <= asm_d;
            to_q          <= to_d;
            data_o_q      <= data_o_d;
            err_q         <= err_d;
            err_cause_q   <= err_cause_d;
            data_req_q    <= data_req_d;
            data_wr_q     <= data_wr_d;
            data_be_q     <= data_be_d;
            data_addr_q   <= data_addr_d;
            data_data_o_q <= data_data_o_d;
        end
    end

    assign stall       = (state_q == BEAT0) || (state_q == BEAT1) ||
                         (((state_q == IDLE) || (state_q == DONE)) && req_present);
    assign valid       = (state_q == DONE);
    assign data_o      = data_o_q;
    assign err         = err_q;
    assign err_cause   = err_cause_q;
    assign data_req    = data_req_q;
    assign data_wr     = data_wr_q;
    assign data_be     = data_be_q;
    assign data_addr   = data_addr_q;
    assign data_data_o = data_data_o_q;

endmodule

// File: doc/rv32_mod_lsu_split.md
Name: rv32_mod_lsu_split

Overview:
Parametrised successor to the single-cycle HART load/store unit. It sits between the HART memory stage and the data bus. It registers every bus transaction and holds it until acknowledged. It transparently splits word-boundary-crossing (misaligned) accesses into two bus beats, sign/zero-extends loads, and reports misalignment, bus error and timeout with a cause code.

Parameters:
MISALIGNED_SPLIT, 1, 1: split boundary-crossing accesses into two beats; 0: reject them with cause MISALIGNED and issue no bus traffic
TIMEOUT_CYCLES, 0, number of bus-wait cycles per beat before abort with cause TIMEOUT; 0 disables the timeout
TO_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be below 2**TO_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_type  in  4  [3]=sign-extend load, [2]=reserved, [1:0]=size (00 none, 01 byte, 10 half, 11 word)
wr  in  1  1=store, 0=load
address  in  32  byte address
data_i  in  32  store data, right-aligned
data_o  out  32  load result, extended; valid when valid=1
valid  out  1  one-cycle completion pulse
err  out  1  with valid: access failed
err_cause  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout
stall  out  1  HART must hold PC and request inputs
data_req  out  1  bus request, registered
data_wr  out  1  bus write, registered
data_be  out  4  byte enables, registered
data_addr  out  32  word-aligned bus address, registered
data_data_o  out  32  lane-shifted store data, registered
data_ack  in  1  beat accepted/completed
data_err  in  1  beat failed
data_data_i  in  32  bus read data

Behaviour:
- Reset is asynchronous, active-high. Clock and reset ports are clk and reset. On reset: state IDLE, all registered outputs 0, err_cause 00, timeout counter 0. Reset mid-transaction drops data_req immediately; no completion is reported.
- States: IDLE, BEAT0, BEAT1, DONE.
- Accept: in IDLE or DONE, when req_type[1:0]!=0, latch the request and compute its parts on the clock edge.
- stall is combinational: 1 in BEAT0 and BEAT1; 1 in IDLE/DONE while a request is present; otherwise 0.
- Crossing condition: half at offset 3, or word at offset 1-3.
- Crossing with MISALIGNED_SPLIT=0: go to DONE with err=1, cause 01. data_req stays 0.
- BEAT0: data_addr={address[31:2],2'b00}. data_be is the low part of the lanes (byte: 1<<off; half: 0011<<off; word: 1111<<off), truncated to 4 bits. Store data is shifted left by 8*off.
- BEAT1 (crossing only): data_addr=BEAT0 address+4 (wraps modulo 2^32). data_be is the upper remainder. Store data is shifted right by 8*(4-off).
- data_req/data_wr/data_be/data_addr/data_data_o stay stable while data_req=1 until data_ack or data_err is sampled.
- data_err has priority over a simultaneous data_ack.
- On ack in BEAT0: go to BEAT1 if crossing, else DONE. On ack in BEAT1: go to DONE. data_req stays high across BEAT0->BEAT1 with no idle cycle.
- Loads: bytes from each beat are captured into an internal 32-bit assembly register. On entry to DONE, data_o = assembled value zero- or sign-extended per req_type[3] and size. Word loads are never extended.
- DONE lasts one cycle: valid=1, and data_req is cleared on that edge. A new request may be accepted in DONE (back-to-back).
- data_err in either beat: go to DONE with err=1, cause 10. If the error occurs in BEAT1 of a split store, BEAT0 is not rolled back.
- Timeout: the counter resets on each beat entry and increments each cycle without ack/err. When it equals TIMEOUT_CYCLES (if nonzero), go to DONE with err=1, cause 11.
- data_o holds its last value outside DONE. For stores, data_o is 0 on completion.
- Latency: an aligned access with ack in the first bus cycle gives accept cycle N, data_req cycle N+1, valid cycle N+2. A split access adds one cycle plus the bus wait.

Test Plan:
- Aligned LW at 0x100, ack in the first request cycle, bus data 0xDEADBEEF: one beat (addr 0x100, be 1111); valid 2 cycles after accept with data_o=0xDEADBEEF; stall high exactly 2 cycles.
- LB signed at 0x103, bus data 0x80000000: be 1000; data_o=0xFFFFFF80. LBU at the same address gives 0x00000080.
- Split LW at 0x0FE: beat0 addr 0x0FC, be 1100, data 0xBBBB_xxxx; beat1 addr 0x100, be 0011, data 0xxxxx_AAAA; data_o=0xAAAABBBB. Repeat with MISALIGNED_SPLIT=0: no data_req, err=1, cause 01.
- Split SH of 0x1234 at 0x0FF: beat0 be 1000, data_data_o[31:24]=0x34; beat1 addr 0x100, be 0001, data_data_o[7:0]=0x12. With data_err on beat1: err=1, cause 10.
- TIMEOUT_CYCLES=4, no ack: abort after 4 wait cycles with err=1, cause 11. Simultaneous ack+err gives cause 10. Asserting reset mid-beat drops data_req at once with no valid.
